// File: rtl/mult_pkg.sv
// Shared types for the multiply dispatcher: FSM states, widths, operand pair.
// Optional accumulator is enabled with MULT_DISPATCH_ACCUM_EN.
package mult_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair FIFO; DEPTH must be a power of two so the pointers wrap freely.
// Push and pop may happen in the same cycle.
module mult_op_fifo
  import mult_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  op_pair_t      wdata,
  input  logic          pop,
  output op_pair_t      rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  op_pair_t        mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mult_dispatch.sv
// Queues operand pairs and feeds an external 32x32 multiplier one at a time.
// Define MULT_DISPATCH_ACCUM_EN to add acc_clr and a 64-bit running sum.
module mult_dispatch
  import mult_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic              mul_busy,
  input  logic [PROD_W-1:0] mul_product,
`ifdef MULT_DISPATCH_ACCUM_EN
  input  logic              acc_clr,
`endif
  output logic [CW-1:0]     pending
);

  state_t            state;
  state_t            state_nxt;
  logic              pop;
  logic              capture;
  logic              slot_free;
  logic              full;
  logic              empty;
  op_pair_t          head;
  op_pair_t          wdata;
  logic [PROD_W-1:0] result;

  assign in_ready  = !full;
  assign wdata     = '{a: in_a, b: in_b};
  assign slot_free = !out_valid || out_ready;
  assign mul_start = (state == ISSUE);

  mult_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

`ifdef MULT_DISPATCH_ACCUM_EN
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] acc_base;

  // A clear landing on a capture cycle starts the new sum from zero.
  assign acc_base = acc_clr ? '0 : acc;
  assign result   = acc_base + mul_product;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (capture) begin
      acc <= result;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end
`else
  assign result = mul_product;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && slot_free) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (mul_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!mul_busy) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        mul_a <= head.a;
        mul_b <= head.b;
      end
      if (capture) begin
        out_valid   <= 1'b1;
        out_product <= result;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_dispatch.sv
// Directed bench for mult_dispatch with a behavioural external multiplier.
// Build with MULT_DISPATCH_ACCUM_EN to also exercise the accumulator.
module tb_mult_dispatch;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_product;
  logic          mul_start;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic          mul_busy;
  logic [63:0]   mul_product;
  logic [CW-1:0] pending;
`ifdef MULT_DISPATCH_ACCUM_EN
  logic          acc_clr;
`endif

  mult_dispatch #(
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_busy    (mul_busy),
    .mul_product (mul_product),
`ifdef MULT_DISPATCH_ACCUM_EN
    .acc_clr     (acc_clr),
`endif
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int misc    = 0;
  int starts  = 0;
  logic hold_busy = 1'b0;
  logic [31:0] ma;
  logic [31:0] mb;

  always @(negedge clk) begin
    if (mul_start) starts++;
  end

  // External multiplier: busy rises after start, falls a few cycles later.
  initial begin
    mul_busy    = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        ma       = mul_a;
        mb       = mul_b;
        mul_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5000 && hold_busy; k++) @(negedge clk);
        mul_product = {32'b0, ma} * {32'b0, mb};
        mul_busy    = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic get(input string nm, input logic [63:0] exp);
    wait_valid(nm);
    chk(nm, out_product, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int   s0;
    logic seen;

    tbl[0] = '{32'd209728609, 32'd212015051, 64'd44465621733294059};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'd0, 32'hFFFF_FFFF, 64'd0};
    tbl[3] = '{32'd3, 32'd5, 64'd15};
    tbl[4] = '{32'd1, 32'd1, 64'd1};
    tbl[5] = '{32'h8000_0000, 32'd2, 64'h1_0000_0000};
    tbl[6] = '{32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000};
    tbl[7] = '{32'd12345, 32'd6789, 64'd83810205};
    tbl[8] = '{32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
`ifdef MULT_DISPATCH_ACCUM_EN
    acc_clr   = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_out_product", out_product, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      s0 = starts;
      push(tbl[i].a, tbl[i].b);
      get($sformatf("vec%0d", i), tbl[i].p);
      chk($sformatf("vec%0d_starts", i), 64'(starts - s0), 64'd1);
    end

    // Backpressure: second issue must wait for the first result to drain.
    s0 = starts;
    push(32'd3, 32'd5);
    push(32'd7, 32'd9);
    wait_valid("bp15");
    chk("bp15", out_product, 64'd15);
    repeat (20) @(negedge clk);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_prod", out_product, 64'd15);
    chk("bp_hold_starts", 64'(starts - s0), 64'd1);
    chk("bp_hold_pending", 64'(pending), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    get("bp63", 64'd63);
    chk("bp_starts", 64'(starts - s0), 64'd2);

    // Full FIFO while the multiplier is stuck busy.
    hold_busy = 1'b1;
    s0 = starts;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(32'(2 * i + 1), 32'(2 * i + 2));
    end
    repeat (2) @(negedge clk);
    chk("full_pending", 64'(pending), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_mul_a", 64'(mul_a), 64'd1);
    chk("full_mul_b", 64'(mul_b), 64'd2);
    chk("full_starts", 64'(starts - s0), 64'd1);
    in_a     = 32'd11;
    in_b     = 32'd12;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("full_refuse_ready", 64'(in_ready), 64'd0);
    chk("full_refuse_pending", 64'(pending), 64'(DEPTH));
    in_valid  = 1'b0;
    hold_busy = 1'b0;
    get("full_r0", 64'd2);
    get("full_r1", 64'd12);
    get("full_r2", 64'd30);
    get("full_r3", 64'd56);
    get("full_r4", 64'd90);
    repeat (30) @(negedge clk);
    chk("full_drain_valid", 64'(out_valid), 64'd0);
    chk("full_drain_pending", 64'(pending), 64'd0);
    chk("full_drain_starts", 64'(starts - s0), 64'(DEPTH + 1));

    // Reset while waiting for the multiplier to finish.
    hold_busy = 1'b1;
    s0 = starts;
    push(32'd4, 32'd4);
    push(32'd6, 32'd6);
    for (int n = 0; n < 100 && starts == s0; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_pending", 64'(pending), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_out_product", out_product, 64'd0);
    chk("mrst_mul_start", 64'(mul_start), 64'd0);
    chk("mrst_mul_a", 64'(mul_a), 64'd0);
    chk("mrst_mul_b", 64'(mul_b), 64'd0);
    reset     = 1'b0;
    hold_busy = 1'b0;
    seen      = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mrst_no_valid", 64'(seen), 64'd0);
    chk("mrst_starts", 64'(starts - s0), 64'd1);
    push(32'd100, 32'd3);
    get("mrst_recover", 64'd300);

`ifdef MULT_DISPATCH_ACCUM_EN
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    push(32'd3, 32'd5);
    get("acc15", 64'd15);
    push(32'd7, 32'd9);
    get("acc78", 64'd78);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    push(32'd2, 32'd2);
    get("acc4", 64'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
